// File: rtl/fetch_sequencer_if.sv
// Fetch-stage control bundle between fetch and the fetch sequencer.
// Fetch side drives PC and the hazard/redirect inputs. The sequencer side drives:
//   - the PC select/target pair,
//   - fetch_valid, flush and misaligned,
//   - the two performance counters.
interface fetch_sequencer_if #(
  parameter int unsigned ADDRESS_BITS = 16,
  parameter int unsigned COUNT_BITS   = 16
);
  logic [ADDRESS_BITS-1:0] PC;
  logic                    stall;
  logic                    imem_ready;
  logic                    branch_valid;
  logic [ADDRESS_BITS-1:0] branch_target;
  logic                    trap;
  logic                    next_PC_select;
  logic [ADDRESS_BITS-1:0] target_PC;
  logic                    fetch_valid;
  logic                    flush;
  logic                    misaligned;
  logic [COUNT_BITS-1:0]   redirect_count;
  logic [COUNT_BITS-1:0]   stall_count;

  // Fetch / pipeline side.
  modport master (
    output PC, stall, imem_ready, branch_valid, branch_target, trap,
    input  next_PC_select, target_PC, fetch_valid, flush, misaligned,
           redirect_count, stall_count
  );

  // Sequencer side.
  modport slave (
    input  PC, stall, imem_ready, branch_valid, branch_target, trap,
    output next_PC_select, target_PC, fetch_valid, flush, misaligned,
           redirect_count, stall_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: each cycle it picks one of three actions for fetch.
//   - advance to PC+4,
//   - hold the current PC,
//   - redirect to a branch or trap target.
// It also flags fetch validity, flushes decode after a redirect and counts
// redirect/stall cycles with saturating counters.
// Ports:
//   clock, reset : sole clock, synchronous active-high reset
//   bus (slave)  : PC/hazard/redirect inputs in; select, target, valid,
//                  flush, misaligned and counters out
module fetch_sequencer #(
  parameter int unsigned           ADDRESS_BITS = 16,
  parameter logic [ADDRESS_BITS-1:0] TRAP_VECTOR = ADDRESS_BITS'(16'h0010),
  parameter int unsigned           COUNT_BITS   = 16
) (
  input  logic                clock,
  input  logic                reset,
  fetch_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {WARMUP, RUN, HOLD, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic                    select_c;
  logic [ADDRESS_BITS-1:0] target_c;
  logic                    valid_c;
  logic                    redirect_inc;
  logic                    stall_inc;
  logic                    misaligned_d;
  logic                    misaligned_q;
  logic [COUNT_BITS-1:0]   redirect_count_q;
  logic [COUNT_BITS-1:0]   stall_count_q;

  // State, misaligned pulse and saturating counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= WARMUP;
      misaligned_q     <= 1'b0;
      redirect_count_q <= '0;
      stall_count_q    <= '0;
    end else begin
      state_q      <= state_d;
      misaligned_q <= misaligned_d;
      if (redirect_inc && (redirect_count_q != '1))
        redirect_count_q <= redirect_count_q + COUNT_BITS'(1);
      if (stall_inc && (stall_count_q != '1))
        stall_count_q <= stall_count_q + COUNT_BITS'(1);
    end
  end

  // Action priority: trap > branch > hold > advance. Reset forces the
  // WARMUP outputs so fetch sits on its reset PC.
  always_comb begin
    state_d      = state_q;
    select_c     = 1'b1;
    target_c     = bus.PC;
    valid_c      = 1'b0;
    redirect_inc = 1'b0;
    stall_inc    = 1'b0;
    misaligned_d = 1'b0;
    if (reset || (state_q == WARMUP)) begin
      state_d = RUN;
    end else if (bus.trap) begin
      target_c     = TRAP_VECTOR;
      state_d      = FLUSH;
      redirect_inc = 1'b1;
    end else if (bus.branch_valid) begin
      target_c     = {bus.branch_target[ADDRESS_BITS-1:2], 2'b00};
      state_d      = FLUSH;
      redirect_inc = 1'b1;
      misaligned_d = |bus.branch_target[1:0];
    end else if (bus.stall || !bus.imem_ready) begin
      state_d   = HOLD;
      stall_inc = 1'b1;
    end else begin
      select_c = 1'b0;
      valid_c  = 1'b1;
      state_d  = RUN;
    end
  end

  assign bus.next_PC_select = select_c;
  assign bus.target_PC      = target_c;
  assign bus.fetch_valid    = valid_c;
  assign bus.flush          = (state_q == FLUSH);
  assign bus.misaligned     = misaligned_q;
  assign bus.redirect_count = redirect_count_q;
  assign bus.stall_count    = stall_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
  localparam int unsigned AB = 16;
  localparam int unsigned CB = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fetch_sequencer_if #(.ADDRESS_BITS(AB), .COUNT_BITS(CB)) bus ();

  fetch_sequencer #(
    .ADDRESS_BITS(AB),
    .TRAP_VECTOR (16'h0010),
    .COUNT_BITS  (CB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Fetch-stage model: the PC register the sequencer steers.
  always @(posedge clock) begin
    if (reset) bus.PC <= '0;
    else       bus.PC <= bus.next_PC_select ? bus.target_PC : bus.PC + 16'd4;
  end

  typedef struct {
    logic [15:0] pc;
    logic        flush;
    logic        mis;
    logic [3:0]  rc;
    logic [3:0]  sc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check combinational outputs, push the state
  // expected after the edge, then pop and compare it.
  task automatic step(input logic st, input logic rdy, input logic bv,
                      input logic [15:0] bt, input logic tr,
                      input logic e_sel, input logic [15:0] e_tgt, input logic e_fv,
                      input logic [15:0] n_pc, input logic n_fl, input logic n_mis,
                      input logic [3:0] n_rc, input logic [3:0] n_sc);
    exp_t e;
    bus.stall = st; bus.imem_ready = rdy; bus.branch_valid = bv;
    bus.branch_target = bt; bus.trap = tr;
    #1;
    chk("next_PC_select", 32'(bus.next_PC_select), 32'(e_sel));
    chk("target_PC",      32'(bus.target_PC),      32'(e_tgt));
    chk("fetch_valid",    32'(bus.fetch_valid),    32'(e_fv));
    sb.push_back('{pc: n_pc, flush: n_fl, mis: n_mis, rc: n_rc, sc: n_sc});
    @(posedge clock); #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'(0), 32'(1));
    end else begin
      e = sb.pop_front();
      chk("PC",             32'(bus.PC),             32'(e.pc));
      chk("flush",          32'(bus.flush),          32'(e.flush));
      chk("misaligned",     32'(bus.misaligned),     32'(e.mis));
      chk("redirect_count", 32'(bus.redirect_count), 32'(e.rc));
      chk("stall_count",    32'(bus.stall_count),    32'(e.sc));
    end
  endtask

  initial begin
    int s;
    bus.stall = 0; bus.imem_ready = 1; bus.branch_valid = 0;
    bus.branch_target = '0; bus.trap = 0;
    @(posedge clock); @(posedge clock); #1;
    // Reset state.
    chk("rst_select", 32'(bus.next_PC_select), 32'(1));
    chk("rst_target", 32'(bus.target_PC),      32'(16'h0000));
    chk("rst_valid",  32'(bus.fetch_valid),    32'(0));
    chk("rst_flush",  32'(bus.flush),          32'(0));
    chk("rst_mis",    32'(bus.misaligned),     32'(0));
    chk("rst_rc",     32'(bus.redirect_count), 32'(0));
    chk("rst_sc",     32'(bus.stall_count),    32'(0));
    chk("rst_pc",     32'(bus.PC),             32'(16'h0000));
    reset = 0;
    // Warmup then advance: PC 0,0,4,8.
    step(0,1,0,16'h0,0, 1,16'h0000,0, 16'h0000,0,0, 4'd0,4'd0);
    step(0,1,0,16'h0,0, 0,16'h0000,1, 16'h0004,0,0, 4'd0,4'd0);
    step(0,1,0,16'h0,0, 0,16'h0004,1, 16'h0008,0,0, 4'd0,4'd0);
    // imem not ready for 3 cycles at 0x0008.
    step(0,0,0,16'h0,0, 1,16'h0008,0, 16'h0008,0,0, 4'd0,4'd1);
    step(0,0,0,16'h0,0, 1,16'h0008,0, 16'h0008,0,0, 4'd0,4'd2);
    step(0,0,0,16'h0,0, 1,16'h0008,0, 16'h0008,0,0, 4'd0,4'd3);
    step(0,1,0,16'h0,0, 0,16'h0008,1, 16'h000C,0,0, 4'd0,4'd3);
    // Branch with stall in same cycle: branch wins, stall not counted.
    step(1,1,1,16'h0100,0, 1,16'h0100,0, 16'h0100,1,0, 4'd1,4'd3);
    step(0,1,0,16'h0,0,    0,16'h0100,1, 16'h0104,0,0, 4'd1,4'd3);
    // Trap and branch together: trap vector, counted once.
    step(0,1,1,16'h0200,1, 1,16'h0010,0, 16'h0010,1,0, 4'd2,4'd3);
    // Misaligned branch issued while in FLUSH: flush held, mis pulse.
    step(0,1,1,16'h0102,0, 1,16'h0100,0, 16'h0100,1,1, 4'd3,4'd3);
    step(0,1,0,16'h0,0,    0,16'h0100,1, 16'h0104,0,0, 4'd3,4'd3);
    // Stall until stall_count saturates at all-ones.
    for (int i = 0; i < 14; i++) begin
      s = (4 + i > 15) ? 15 : 4 + i;
      step(1,1,0,16'h0,0, 1,16'h0104,0, 16'h0104,0,0, 4'd3,4'(s));
    end
    // Trap beats a misaligned branch: no misaligned pulse.
    step(0,1,1,16'h0203,1, 1,16'h0010,0, 16'h0010,1,0, 4'd4,4'd15);
    // Mid-run reset: reset-state comb outputs, everything clears.
    reset = 1;
    step(0,1,0,16'h0,0, 1,16'h0010,0, 16'h0000,0,0, 4'd0,4'd0);
    reset = 0;
    step(0,1,0,16'h0,0, 1,16'h0000,0, 16'h0000,0,0, 4'd0,4'd0);
    step(0,1,0,16'h0,0, 0,16'h0000,1, 16'h0004,0,0, 4'd0,4'd0);
    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
